// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave time-entry path: key codes,
// BCD digit widths and the loader state type.
package microwave_pkg;

    localparam int unsigned MU_W  = 4;
    localparam int unsigned ST_W  = 3;
    localparam int unsigned SU_W  = 4;
    localparam int unsigned KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_START = 4'd10;
    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'd11;

    localparam logic [1:0] MAX_DIGITS = 2'd3;
    localparam logic [SU_W-1:0] MAX_SECS_TENS = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_LOAD,
        ST_RUNNING
    } state_t;

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/time_entry_loader_if.sv
// Keypad / countdown-timer side bundle of the time entry loader.
interface time_entry_loader_if;
    import microwave_pkg::*;

    logic             key_valid;
    logic [KEY_W-1:0] key_code;
    logic             load_ready;
    logic             timer_done;
    logic             load_valid;
    logic [MU_W-1:0]  load_minutes_units;
    logic [ST_W-1:0]  load_seconds_tens;
    logic [SU_W-1:0]  load_seconds_units;
    logic             running;
    logic             abort;
    logic             key_err;

    modport master (
        output key_valid, key_code, load_ready, timer_done,
        input  load_valid, load_minutes_units, load_seconds_tens,
               load_seconds_units, running, abort, key_err
    );

    modport slave (
        input  key_valid, key_code, load_ready, timer_done,
        output load_valid, load_minutes_units, load_seconds_tens,
               load_seconds_units, running, abort, key_err
    );

endinterface

// File: rtl/time_entry_loader_bcd_entry_shift.sv
// Three-digit BCD entry register (M:ST SU) with digit count, quick-load,
// clear and the seconds-tens range check for the next shift.
module bcd_entry_shift
    import microwave_pkg::*;
(
    input  logic            CLK,
    input  logic            Reset,
    input  logic            clr,
    input  logic            load_en,
    input  logic [ST_W-1:0] load_st,
    input  logic [SU_W-1:0] load_su,
    input  logic            shift_en,
    input  logic [SU_W-1:0] digit,
    output logic [MU_W-1:0] mu,
    output logic [ST_W-1:0] st,
    output logic [SU_W-1:0] su,
    output logic            shift_ok,
    output logic            is_zero
);

    logic [1:0] count;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            mu    <= '0;
            st    <= '0;
            su    <= '0;
            count <= '0;
        end else if (clr) begin
            mu    <= '0;
            st    <= '0;
            su    <= '0;
            count <= '0;
        end else if (load_en) begin
            mu <= '0;
            st <= load_st;
            su <= load_su;
        end else if (shift_en) begin
            mu    <= MU_W'(st);
            st    <= ST_W'(su);
            su    <= digit;
            count <= count + 2'd1;
        end
    end

    // The current units digit becomes seconds-tens after a shift, so it must be 0-5.
    assign shift_ok = (count != MAX_DIGITS) && (su <= MAX_SECS_TENS);
    assign is_zero  = (mu == '0) && (st == '0) && (su == '0);

endmodule

// File: rtl/time_entry_loader.sv
// Keypad time-entry controller: collects up to three BCD digits and hands
// the value to the countdown timer with a valid/ready load handshake.
module time_entry_loader
    import microwave_pkg::*;
#(
    parameter int unsigned QUICK_SECS_TENS  = 3,
    parameter int unsigned QUICK_SECS_UNITS = 0
)
(
    input  logic                CLK,
    input  logic                Reset,
    time_entry_loader_if.slave  bus
);

    state_t state, state_next;

    logic            clr, load_en, shift_en, shift_ok, is_zero;
    logic            key_err_next, abort_next;
    logic            key_err_q, abort_q;
    logic [MU_W-1:0] mu;
    logic [ST_W-1:0] st;
    logic [SU_W-1:0] su;

    bcd_entry_shift u_digits (
        .CLK      (CLK),
        .Reset    (Reset),
        .clr      (clr),
        .load_en  (load_en),
        .load_st  (ST_W'(QUICK_SECS_TENS)),
        .load_su  (SU_W'(QUICK_SECS_UNITS)),
        .shift_en (shift_en),
        .digit    (bus.key_code),
        .mu       (mu),
        .st       (st),
        .su       (su),
        .shift_ok (shift_ok),
        .is_zero  (is_zero)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            key_err_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state     <= state_next;
            key_err_q <= key_err_next;
            abort_q   <= abort_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr          = 1'b0;
        load_en      = 1'b0;
        shift_en     = 1'b0;
        key_err_next = 1'b0;
        abort_next   = 1'b0;
        case (state)
            ST_IDLE, ST_ENTRY: begin
                if (bus.key_valid) begin
                    if (is_digit(bus.key_code)) begin
                        if (shift_ok) begin
                            shift_en   = 1'b1;
                            state_next = ST_ENTRY;
                        end else begin
                            key_err_next = 1'b1;
                        end
                    end else if (bus.key_code == KEY_START) begin
                        if (state == ST_IDLE) begin
                            load_en    = 1'b1;
                            state_next = ST_LOAD;
                        end else if (is_zero) begin
                            key_err_next = 1'b1;
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end else if (bus.key_code == KEY_CLEAR) begin
                        clr        = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        key_err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                // CLEAR takes priority over a same-cycle load acceptance.
                if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
                    clr        = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    key_err_next = bus.key_valid;
                    if (bus.load_ready) state_next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                // timer_done swallows any key arriving in the same cycle.
                if (bus.timer_done) begin
                    clr        = 1'b1;
                    state_next = ST_IDLE;
                end else if (bus.key_valid) begin
                    if (bus.key_code == KEY_CLEAR) begin
                        clr        = 1'b1;
                        abort_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        key_err_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.load_valid         = (state == ST_LOAD);
    assign bus.running            = (state == ST_RUNNING);
    assign bus.key_err            = key_err_q;
    assign bus.abort              = abort_q;
    assign bus.load_minutes_units = mu;
    assign bus.load_seconds_tens  = st;
    assign bus.load_seconds_units = su;

endmodule
